// File: rtl/ysyx_22041207_pkg.sv
// ysyx_22041207_pkg: shared hazard-controller state encoding and constants
package ysyx_22041207_pkg;
  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MEMWAIT = 2'd1,
    HZ_DRAIN   = 2'd2
  } hz_state_e;
  localparam int HZ_DRAIN_DEPTH = 2;
  localparam logic [4:0] HZ_X0 = 5'd0;
endpackage

// File: rtl/ysyx_22041207_hazard_perf.sv
// ysyx_22041207_hazard_perf: wrapping stall-cycle and redirect-event counters
// Ports: clk, rst (sync, active-high), stall_inc/flush_inc event strobes,
// stall_cycles/flush_events 32-bit counts.
module ysyx_22041207_hazard_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);
  logic [31:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = stall_q + 32'(stall_inc);
    flush_d = flush_q + 32'(flush_inc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
endmodule

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// ysyx_22041207_hazard_ctrl: five-stage pipeline stall/bubble/flush sequencer
// Inputs: ID source regs and CSR flag, EX destination/load/redirect, MEM
// request/ack. Outputs: Mealy PC stall, per-register bubble/flush, ID_EX
// NOP insert, and perf counters (live only with YSYX_22041207_HAZARD_PERF_EN).
module ysyx_22041207_hazard_ctrl
  import ysyx_22041207_pkg::*;
#(
  parameter int DRAIN_DEPTH = HZ_DRAIN_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1addr,
  input  logic [4:0]  id_rs2addr,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_csr,
  input  logic [4:0]  ex_rwaddr,
  input  logic        ex_writeRD,
  input  logic        ex_memoryReadWen,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        if_id_bubble,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        mem_wb_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        id_ex_clear,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);
  localparam int CW = $clog2(DRAIN_DEPTH + 2);
  hz_state_e state_q, state_d, eff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ret_q, ret_d;
  logic load_use, freeze, redirect, drain_hold, enter_drain, hold;
  always_comb begin
    // The ack cycle of MEMWAIT behaves like the state the freeze interrupted.
    eff = (state_q == HZ_MEMWAIT) ? (ret_q ? HZ_DRAIN : HZ_RUN) : state_q;
    freeze = (state_q == HZ_MEMWAIT) ? !mem_ack : (mem_req & !mem_ack);
    load_use = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != HZ_X0) &
               ((id_use_rs1 & (id_rs1addr == ex_rwaddr)) | (id_use_rs2 & (id_rs2addr == ex_rwaddr)));
    redirect = !rst & !freeze & ex_redirect;
    // Counter value 1 is the last drain cycle: it reaches 0 here and releases the CSR.
    drain_hold = (eff == HZ_DRAIN) & (cnt_q > CW'(1));
    enter_drain = (eff == HZ_RUN) & !load_use & id_csr;
    hold = !rst & !freeze & !redirect & (drain_hold | ((eff == HZ_RUN) & (load_use | id_csr)));
    pc_stall = !rst & (freeze | hold);
    if_id_bubble = pc_stall;
    id_ex_bubble = !rst & freeze;
    ex_mem_bubble = id_ex_bubble;
    mem_wb_bubble = id_ex_bubble;
    if_id_flush = rst | redirect;
    id_ex_flush = if_id_flush;
    mem_wb_flush = rst | freeze;
    id_ex_clear = hold;
    state_d = freeze ? HZ_MEMWAIT : redirect ? HZ_RUN : (enter_drain | drain_hold) ? HZ_DRAIN : HZ_RUN;
    ret_d = freeze & ((state_q == HZ_MEMWAIT) ? ret_q : (state_q == HZ_DRAIN));
    cnt_d = freeze ? cnt_q : redirect ? '0 : enter_drain ? CW'(DRAIN_DEPTH) : drain_hold ? cnt_q - CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      cnt_q <= '0;
      ret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ret_q <= ret_d;
    end
  end
`ifdef YSYX_22041207_HAZARD_PERF_EN
  ysyx_22041207_hazard_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (pc_stall),
    .flush_inc    (redirect),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: tb/tb_ysyx_22041207_hazard_ctrl.sv
// tb_ysyx_22041207_hazard_ctrl: directed scoreboard bench for the hazard controller
module tb_ysyx_22041207_hazard_ctrl;
`ifdef YSYX_22041207_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // ctl bits: pc_stall, if_id_bub, id_ex_bub, ex_mem_bub, mem_wb_bub, if_id_fl, id_ex_fl, mem_wb_fl, id_ex_clear
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] STL  = 9'b110000001;
  localparam logic [8:0] RD   = 9'b000001100;
  localparam logic [8:0] FRZ  = 9'b111110010;
  localparam logic [8:0] RST  = 9'b000001110;
  typedef struct packed {
    logic [8:0]  ctl;
    logic        cc;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1addr, id_rs2addr, ex_rwaddr;
  logic id_use_rs1, id_use_rs2, id_csr, ex_writeRD, ex_memoryReadWen, ex_redirect, mem_req, mem_ack;
  logic pc_stall, if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
  logic if_id_flush, id_ex_flush, mem_wb_flush, id_ex_clear;
  logic [31:0] stall_cycles, flush_events;
  exp_t exp_q[$];
  string name_q[$];
  exp_t e;
  string n;
  logic [8:0] act;
  int vectors = 0;
  int miscompares = 0;
  ysyx_22041207_hazard_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1addr       (id_rs1addr),
    .id_rs2addr       (id_rs2addr),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .id_csr           (id_csr),
    .ex_rwaddr        (ex_rwaddr),
    .ex_writeRD       (ex_writeRD),
    .ex_memoryReadWen (ex_memoryReadWen),
    .ex_redirect      (ex_redirect),
    .mem_req          (mem_req),
    .mem_ack          (mem_ack),
    .pc_stall         (pc_stall),
    .if_id_bubble     (if_id_bubble),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_bubble    (ex_mem_bubble),
    .mem_wb_bubble    (mem_wb_bubble),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .mem_wb_flush     (mem_wb_flush),
    .id_ex_clear      (id_ex_clear),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = {pc_stall, if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
             if_id_flush, id_ex_flush, mem_wb_flush, id_ex_clear};
      vectors++;
      if (act !== e.ctl || (e.cc && (stall_cycles !== e.sc || flush_events !== e.fe))) begin
        miscompares++;
        $display("FAIL %s: got ctl=%b sc=%0d fe=%0d, want ctl=%b sc=%0d fe=%0d%s",
                 n, act, stall_cycles, flush_events, e.ctl, e.sc, e.fe, e.cc ? "" : " (counters unchecked)");
      end
    end
  end
  task automatic idle();
    rst = 0; id_rs1addr = 0; id_rs2addr = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_csr = 0;
    ex_rwaddr = 0; ex_writeRD = 0; ex_memoryReadWen = 0; ex_redirect = 0; mem_req = 0; mem_ack = 0;
  endtask
  task automatic load_ex(input logic [4:0] rd);
    ex_rwaddr = rd; ex_writeRD = 1; ex_memoryReadWen = 1;
  endtask
  task automatic cyc(input logic [8:0] c, input string nm, input bit cc = 0, input int sc = 0, input int fe = 0);
    exp_q.push_back('{ctl: c, cc: cc, sc: PERF ? 32'(sc) : 32'd0, fe: PERF ? 32'(fe) : 32'd0});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    idle(); rst = 1;                                 cyc(RST, "reset_a");
    idle(); rst = 1; mem_req = 1;                    cyc(RST, "reset_b", 1, 0, 0);
    idle();                                          cyc(NONE, "post_reset", 1, 0, 0);
    idle(); load_ex(5); id_rs1addr = 5; id_use_rs1 = 1; cyc(STL, "loaduse_rs1");
    idle(); ex_rwaddr = 5; id_rs1addr = 5; id_use_rs1 = 1; cyc(NONE, "loaduse_after");
    idle(); load_ex(0); id_rs1addr = 0; id_use_rs1 = 1; cyc(NONE, "loaduse_x0");
    idle(); load_ex(7); id_rs2addr = 7; id_use_rs2 = 1; cyc(STL, "loaduse_rs2");
    idle(); load_ex(7); id_rs1addr = 7; id_use_rs1 = 0; cyc(NONE, "loaduse_unused_src");
    idle(); load_ex(7); ex_writeRD = 0; id_rs1addr = 7; id_use_rs1 = 1; cyc(NONE, "load_nowrite");
    idle(); ex_redirect = 1;                         cyc(RD, "redirect");
    idle();                                          cyc(NONE, "after_redirect", 1, 2, 1);
    idle(); mem_req = 1;                             cyc(FRZ, "memwait_1");
    idle(); mem_req = 1; ex_redirect = 1;            cyc(FRZ, "memwait_2_redir_ignored");
    idle(); mem_req = 1;                             cyc(FRZ, "memwait_3");
    idle(); mem_req = 1; mem_ack = 1;                cyc(NONE, "memwait_ack");
    idle();                                          cyc(NONE, "after_memwait", 1, 5, 1);
    idle(); id_csr = 1;                              cyc(STL, "csr_a");
    idle(); id_csr = 1;                              cyc(STL, "csr_b");
    idle(); id_csr = 1;                              cyc(NONE, "csr_release");
    idle(); id_csr = 1;                              cyc(STL, "csr2_a");
    idle(); id_csr = 1;                              cyc(STL, "csr2_b");
    idle(); id_csr = 1;                              cyc(NONE, "csr2_release");
    idle();                                          cyc(NONE, "after_csr", 1, 9, 1);
    idle(); id_csr = 1;                              cyc(STL, "csrmem_a");
    idle(); id_csr = 1; mem_req = 1;                 cyc(FRZ, "csrmem_frz1");
    idle(); id_csr = 1; mem_req = 1;                 cyc(FRZ, "csrmem_frz2");
    idle(); id_csr = 1; mem_ack = 1;                 cyc(STL, "csrmem_ack_drain");
    idle(); id_csr = 1;                              cyc(NONE, "csrmem_release");
    idle();                                          cyc(NONE, "after_csrmem", 1, 13, 1);
    idle(); load_ex(9); id_rs1addr = 9; id_use_rs1 = 1; ex_redirect = 1; cyc(RD, "loaduse_plus_redirect");
    idle();                                          cyc(NONE, "after_lu_redir", 1, 13, 2);
    idle(); id_csr = 1;                              cyc(STL, "drain_abort_a");
    idle(); id_csr = 1; ex_redirect = 1;             cyc(RD, "drain_abort_redir");
    idle();                                          cyc(NONE, "drain_aborted", 1, 14, 3);
    idle(); mem_req = 1;                             cyc(FRZ, "rst_memwait_frz");
    idle(); rst = 1; mem_req = 1; mem_ack = 1;       cyc(RST, "rst_in_memwait");
    idle(); mem_ack = 1;                             cyc(NONE, "after_rst_memwait", 1, 0, 0);
    idle();                                          cyc(NONE, "final_idle", 1, 0, 0);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
